// File: rtl/vending_display.sv
// -----------------------------------------------------------------------------
// vending_display
//
// Drives a 4-digit multiplexed, active-low seven-segment display from the
// vending_machine outputs. The leftmost digit shows a letter for the machine
// state. The remaining three digits show the money amount as D.CC dollars.
//
// A sequential shift-add-3 converter turns the binary cents value into BCD.
// The displayed BCD registers are loaded in a single cycle once a conversion
// has finished, so the display always shows a complete value.
//
// Optional feature macro: VEND_DISP_BLINK_EN
//   Defined   : in update mode (state_in == 3'b011) the money digits blink,
//               driven by the MSB of a BLINK_W-bit free-running counter.
//   Undefined : no blink counter; the money digits are always shown.
//
// Parameters:
//   REFRESH_W  width of the scan counter; the digit advances every
//              2^(REFRESH_W-2) cycles
//   BLINK_W    width of the blink counter (only used with VEND_DISP_BLINK_EN)
//
// Ports:
//   clk        system clock (shared with vending_machine)
//   rst        synchronous active-high reset
//   state_in   machine state code (vending_machine output_state)
//   money_in   amount in cents, 0..127 (vending_machine output_money)
//   seg        active-low segments {g,f,e,d,c,b,a}, registered
//   an         active-low anodes; an[3] is the leftmost digit, registered
//   dp         active-low decimal point, registered
//   conv_busy  high while a BCD conversion is in progress
// -----------------------------------------------------------------------------
module vending_display #(
  parameter int REFRESH_W = 17,
  parameter int BLINK_W   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state_in,
  input  logic [6:0] money_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       conv_busy
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } conv_state_t;

  // Converter state
  conv_state_t r_state;
  logic [6:0]  r_bin;        // binary value being shifted out MSB-first
  logic [6:0]  r_last;       // value of the most recently started conversion
  logic [11:0] r_bcd_scr;    // scratch BCD {hund, tens, ones}
  logic [2:0]  r_shift_cnt;
  logic        r_busy;

  // Displayed digits (only ever loaded together from the scratch BCD)
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;

  // Scan and output registers
  logic [REFRESH_W-1:0] r_scan;
  logic [6:0]           r_seg;
  logic [3:0]           r_an;
  logic                 r_dp;

  logic [11:0] w_bcd_adj;
  logic [1:0]  w_sel;
  logic        w_blank;
  logic [6:0]  w_seg_next;
  logic        w_dp_next;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_letter(input logic [2:0] s);
    logic [6:0] r;
    case (s)
      3'b000:  r = 7'b0001100;  // P
      3'b001:  r = 7'b0011000;  // q
      3'b010:  r = 7'b0101111;  // r
      3'b011:  r = 7'b1000001;  // U
      3'b100:  r = 7'b0000011;  // b
      default: r = 7'b0111111;  // dash for unused codes
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_BLANK;   // invalid BCD shows nothing
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Binary-to-BCD converter: IDLE -> SHIFT (7 cycles) -> COMMIT -> IDLE
  // ---------------------------------------------------------------------------
  assign w_bcd_adj = {add3(r_bcd_scr[11:8]), add3(r_bcd_scr[7:4]),
                      add3(r_bcd_scr[3:0])};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_last      <= '0;
      r_bcd_scr   <= '0;
      r_shift_cnt <= '0;
      r_busy      <= 1'b0;
      r_hund      <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A new value is only taken here, so a change during SHIFT or
          // COMMIT is picked up on the first IDLE cycle afterwards.
          if (money_in != r_last) begin
            r_bin       <= money_in;
            r_last      <= money_in;
            r_bcd_scr   <= '0;
            r_shift_cnt <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Correct nibbles >= 5, then shift the binary MSB into the BCD LSB.
          {r_bcd_scr, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_shift_cnt        <= r_shift_cnt + 3'd1;
          if (r_shift_cnt == 3'd6) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_hund  <= r_bcd_scr[11:8];
          r_tens  <= r_bcd_scr[7:4];
          r_ones  <= r_bcd_scr[3:0];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink of the money digits in update mode
  // ---------------------------------------------------------------------------
`ifdef VEND_DISP_BLINK_EN
  logic [BLINK_W-1:0] r_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + BLINK_W'(1);
    end
  end

  assign w_blank = (state_in == 3'b011) && r_blink[BLINK_W-1];
`else
  // BLINK_W is referenced only so both builds share one parameter list;
  // the expression is constant zero.
  assign w_blank = 1'b0 && (BLINK_W > 0);
`endif

  // ---------------------------------------------------------------------------
  // Digit scan and registered segment outputs
  // ---------------------------------------------------------------------------
  assign w_sel = r_scan[REFRESH_W-1 -: 2];

  always_comb begin
    w_seg_next = SEG_BLANK;
    w_dp_next  = 1'b1;
    case (w_sel)
      2'd3: w_seg_next = seg_letter(state_in);
      2'd2: begin
        w_seg_next = seg_digit(r_hund);
        w_dp_next  = 1'b0;
      end
      2'd1: w_seg_next = seg_digit(r_tens);
      default: w_seg_next = seg_digit(r_ones);
    endcase
    // The letter digit is never blanked; the anode stays driven either way.
    if (w_blank && (w_sel != 2'd3)) begin
      w_seg_next = SEG_BLANK;
      w_dp_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_seg  <= SEG_BLANK;
      r_an   <= 4'b1111;
      r_dp   <= 1'b1;
    end else begin
      r_scan <= r_scan + REFRESH_W'(1);
      r_seg  <= w_seg_next;
      r_an   <= ~(4'b0001 << w_sel);
      r_dp   <= w_dp_next;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = r_dp;
  assign conv_busy = r_busy;

endmodule

// File: tb/tb_vending_display.sv
// -----------------------------------------------------------------------------
// tb_vending_display
//
// Directed and random stimulus for vending_display with a short scan period.
// A cycle-level behavioural model (integer cents, a busy countdown and the
// segment tables) predicts seg/an/dp/conv_busy after every clock edge.
// -----------------------------------------------------------------------------
module tb_vending_display;

  localparam int RW = 4;
  localparam int BW = 6;
`ifdef VEND_DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [6:0] LET [8] = '{7'b0001100, 7'b0011000, 7'b0101111,
                                     7'b1000001, 7'b0000011, 7'b0111111,
                                     7'b0111111, 7'b0111111};
  localparam logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                      7'b0110000, 7'b0011001, 7'b0010010,
                                      7'b0000010, 7'b1111000, 7'b0000000,
                                      7'b0010000};
  localparam logic [3:0] ANT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       clk;
  logic       rst;
  logic [2:0] state_in;
  logic [6:0] money_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       conv_busy;

  int n_checks;
  int n_err;

  // Model state
  int         m_scan;
  int         m_blink;
  int         m_disp;
  int         m_last;
  int         m_conv;
  int         m_busy_left;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_dp;
  logic       e_busy;

  vending_display #(
    .REFRESH_W (RW),
    .BLINK_W   (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .money_in  (money_in),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .conv_busy (conv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs 1 time unit later.
  task automatic step();
    logic [2:0] st;
    logic [6:0] mo;
    logic       rr;
    int         sel;
    bit         blank;
    @(posedge clk);
    st = state_in;
    mo = money_in;
    rr = rst;
    if (rr) begin
      e_seg = 7'b1111111; e_an = 4'b1111; e_dp = 1'b1; e_busy = 1'b0;
      m_scan = 0; m_blink = 0; m_disp = 0; m_last = 0; m_conv = 0;
      m_busy_left = 0;
    end else begin
      sel   = (m_scan >> (RW - 2)) % 4;
      blank = BLINK_ON && (st == 3'b011) && (((m_blink >> (BW - 1)) % 2) == 1)
              && (sel != 3);
      e_an  = ANT[sel];
      e_dp  = 1'b1;
      if (blank) begin
        e_seg = 7'b1111111;
      end else begin
        case (sel)
          3: e_seg = LET[st];
          2: begin e_seg = DIG[m_disp / 100]; e_dp = 1'b0; end
          1: e_seg = DIG[(m_disp / 10) % 10];
          default: e_seg = DIG[m_disp % 10];
        endcase
      end
      m_scan  = (m_scan + 1) % (1 << RW);
      m_blink = (m_blink + 1) % (1 << BW);
      // Conversion: busy for 8 edges, display takes the captured value on
      // the 8th; a new value is only looked at once not busy.
      if (m_busy_left == 0) begin
        if (int'(mo) != m_last) begin
          m_last = int'(mo);
          m_conv = int'(mo);
          m_busy_left = 8;
        end
      end else begin
        m_busy_left--;
        if (m_busy_left == 0) m_disp = m_conv;
      end
      e_busy = (m_busy_left != 0);
    end
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("conv_busy", 32'(conv_busy), 32'(e_busy));
  endtask

  task automatic measure_busy(output int hi);
    int w;
    hi = 0;
    w  = 0;
    while (conv_busy !== 1'b1 && w < 6) begin step(); w++; end
    while (conv_busy === 1'b1 && hi < 20) begin step(); hi++; end
  endtask

  task automatic wait_busy_rise();
    int w;
    w = 0;
    while (conv_busy !== 1'b1 && w < 6) begin step(); w++; end
    chk("busy_rise", 32'(conv_busy), 32'(1));
  endtask

  initial begin
    int hi;
    int hold;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    state_in = 3'b000;
    money_in = 7'd0;
    #2;
    step();
    step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'(1));
    chk("rst_busy", 32'(conv_busy), 32'(0));

    // Full scans with zero money: 0.00 and letter P, no conversion
    rst = 1'b0;
    repeat (40) step();

    // 0 -> 45
    money_in = 7'd45;
    measure_busy(hi);
    chk("busy_len_45", 32'(hi), 32'(8));
    repeat (20) step();

    // 127 -> 1.27
    money_in = 7'd127;
    measure_busy(hi);
    chk("busy_len_127", 32'(hi), 32'(8));
    repeat (20) step();

    // 5, then 10 applied on the third SHIFT cycle
    money_in = 7'd5;
    wait_busy_rise();
    step();
    step();
    money_in = 7'd10;
    repeat (40) step();

    // State sweep, changing every cycle so each code meets the letter slot
    for (int i = 0; i < 64; i++) begin
      state_in = 3'(i % 8);
      step();
    end

    // Reset in the middle of converting 90
    state_in = 3'b010;
    money_in = 7'd90;
    wait_busy_rise();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(conv_busy), 32'(0));
    chk("midrst_an", 32'(an), 32'hF);
    rst = 1'b0;
    measure_busy(hi);
    chk("busy_len_90", 32'(hi), 32'(8));
    repeat (20) step();

    // Update mode vs. non-update mode with 25 cents
    state_in = 3'b011;
    money_in = 7'd25;
    repeat (160) step();
    state_in = 3'b100;
    repeat (80) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) money_in = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) != 0) state_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      hold = $urandom_range(1, 15);
      repeat (hold) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vending_display.md
Name: vending_display

Overview:
- Downstream consumer of vending_machine.
- Takes output_state[2:0] and output_money[6:0] (cents, 0..127) and drives a 4-digit multiplexed, active-low seven-segment display.
- Leftmost digit shows a state letter; the other three show money as D.CC dollars.
- Binary-to-BCD conversion runs sequentially (shift-add-3) so the display updates atomically.

Parameters:
- REFRESH_W, 17, width of the scan counter; the digit advances every 2^(REFRESH_W-2) cycles.
- BLINK_W, 25, width of the blink counter; used only with VEND_DISP_BLINK_EN.

Ports:
- clk  input  1  system clock, same as vending_machine.
- rst  input  1  synchronous active-high reset.
- state_in  input  3  connects to output_state.
- money_in  input  7  connects to output_money, unsigned cents.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
- an  output  4  active-low anodes; an[3] is the leftmost digit. Registered.
- dp  output  1  active-low decimal point, registered.
- conv_busy  output  1  high while a BCD conversion is in progress.

Behaviour:
- Reset (clk edge with rst=1):
  - seg=7'b1111111, an=4'b1111, dp=1, conv_busy=0.
  - Scan counter=0, blink counter=0.
  - Displayed BCD regs {hund,tens,ones}=0, last_converted=0, FSM=IDLE.
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: if money_in != last_converted, capture money_in into shift reg and last_converted, clear scratch BCD, go to SHIFT, conv_busy=1.
  - SHIFT: exactly 7 cycles. Each cycle, add 3 to every scratch BCD nibble >=5, then shift left 1 bit, MSB of binary into BCD.
  - COMMIT: 1 cycle. Copy scratch BCD to displayed regs, conv_busy=0, go to IDLE.
  - Latency: first differing money_in sampled in IDLE -> displayed regs updated 8 cycles later, i.e. conv_busy high for 8 cycles.
  - money_in changes during SHIFT/COMMIT: the current conversion completes unchanged. The next IDLE cycle sees the mismatch and restarts.
  - A single value must never display partially updated.
  - Max 127 -> hund=1, tens=2, ones=7. The hundreds nibble never exceeds 1.
- Scan:
  - Free-running counter, wraps at 2^REFRESH_W.
  - sel = counter[REFRESH_W-1:REFRESH_W-2].
  - Registered outputs take the sel value one cycle later: an=~(4'b0001<<sel).
- Digit content:
  - sel=3: state letter from the live state_in.
  - sel=2: hund, with dp=0.
  - sel=1: tens.
  - sel=0: ones.
  - dp=1 for every sel other than 2.
- Letters (seg):
  - 000 P=7'b0001100
  - 001 q=7'b0011000
  - 010 r=7'b0101111
  - 011 U=7'b1000001
  - 100 b=7'b0000011
  - 101..111 dash=7'b0111111
- Digits 0..9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any BCD nibble >9 (must not occur) shows blank 7'b1111111.
- Reset mid-conversion: abort immediately to reset values. money_in is re-converted after rst falls if it is nonzero.

Optional Feature:
- Macro VEND_DISP_BLINK_EN.
- Defined:
  - Blink counter increments every cycle.
  - While state_in==3'b011 (update mode) and blink counter MSB=1, the three money digits (sel 0..2) show blank seg=7'b1111111, dp=1, with the anode still driven.
  - The letter digit never blinks.
- Undefined: no blink counter is present, money digits are always shown, and the BLINK_W parameter is unused.

Test Plan:
- Reset, then hold rst=0, state_in=000, money_in=0 for a full scan: an cycles 1110,1101,1011,0111.
  - Expected seg: 1000000 on digits 0..2 and 0001100 on an=0111.
  - dp=0 only with an=1011.
  - conv_busy never rises.
- money_in 0->45: conv_busy high for exactly 8 cycles, then hund/tens/ones=0/4/5, i.e. seg 1000000/0011001/0010010.
- money_in=127: expect digits 1/2/7. money_in 5->10 changed on the 3rd SHIFT cycle: display goes to 0.05 first, then restarts and shows 0.10, with no other intermediate value.
- Sweep state_in 000..111 with sel=3: seg matches P,q,r,U,b,-,-,- encodings, with the one-cycle register delay checked.
- rst asserted mid-conversion with money_in=90: outputs go to reset values next edge. After release, conv_busy rises, then 0.90 is displayed.
- With VEND_DISP_BLINK_EN, REFRESH_W=4, BLINK_W=6, state_in=011, money_in=25: money digits blank whenever the blink MSB=1 and the letter U stays lit. With state_in=100 there is no blanking.
